// File: rtl/sequence_store_module.sv
// sequence_store_module: Simon-game sequence memory.
// Requests one colour per round from the random generator, stores it, plays the
// stored sequence back as timed colour codes and checks player presses against it.
//
// Ports:
//   i_clk, i_rst_n             clock (posedge), asynchronous active-low reset
//   i_clear                    clear the sequence (honoured in IDLE only)
//   i_extend                   request and append one new element
//   o_gen_enable               generator enable, high whenever out of reset
//   o_gen_trigger              one-cycle generator trigger
//   i_gen_done, i_gen_value    generator result strobe and colour
//   i_play_start               start playback of the stored sequence
//   o_play_color               0 = dark, 1-4 = colour being shown
//   o_busy                     high in any state other than IDLE
//   i_check_valid/value        player press strobe and colour
//   o_check_ok/err, o_round_done  registered one-cycle check results
//   o_length, o_full           stored element count, count == MAX_LEN
//   o_gen_timeout              generator timeout pulse (GEN_TIMEOUT_EN only)
//
// Optional feature macro: GEN_TIMEOUT_EN (bounded wait for the generator).
module sequence_store_module #(
    parameter int unsigned MAX_LEN     = 32,
    parameter int unsigned ON_CYCLES   = 50,
    parameter int unsigned OFF_CYCLES  = 25,
    parameter int unsigned GEN_TIMEOUT = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_clear,
    input  logic                           i_extend,
    output logic                           o_gen_enable,
    output logic                           o_gen_trigger,
    input  logic                           i_gen_done,
    input  logic [2:0]                     i_gen_value,
    input  logic                           i_play_start,
    output logic [2:0]                     o_play_color,
    output logic                           o_busy,
    input  logic                           i_check_valid,
    input  logic [2:0]                     i_check_value,
    output logic                           o_check_ok,
    output logic                           o_check_err,
    output logic                           o_round_done,
`ifdef GEN_TIMEOUT_EN
    output logic                           o_gen_timeout,
`endif
    output logic [$clog2(MAX_LEN+1)-1:0]   o_length,
    output logic                           o_full
);

    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TMR_MAX = (ON_CYCLES > OFF_CYCLES)
                                      ? ((ON_CYCLES > GEN_TIMEOUT) ? ON_CYCLES : GEN_TIMEOUT)
                                      : ((OFF_CYCLES > GEN_TIMEOUT) ? OFF_CYCLES : GEN_TIMEOUT);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_GEN, PLAY_ON, PLAY_OFF} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   length_q, length_d;
    logic [LEN_W-1:0]   play_idx_q, play_idx_d;
    logic [LEN_W-1:0]   chk_idx_q, chk_idx_d;
    logic [LEN_W-1:0]   chk_next;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               mem_we;
    logic [2:0]         gen_fold;
    logic [2:0]         play_color_d;
    logic               check_ok_d, check_err_d, round_done_d;
`ifdef GEN_TIMEOUT_EN
    logic               gen_timeout_d;
`endif

    logic [2:0] mem [MAX_LEN];

    // Out-of-range generator values fold onto 1-4 via the low two bits of v-1.
    assign gen_fold = 3'((i_gen_value - 3'd1) & 3'b011) + 3'd1;
    assign chk_next = chk_idx_q + LEN_W'(1);
    assign o_length = length_q;

    // Sequence memory; contents are not reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[length_q[IDX_W-1:0]] <= gen_fold;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        length_d     = length_q;
        play_idx_d   = play_idx_q;
        chk_idx_d    = chk_idx_q;
        timer_d      = timer_q;
        mem_we       = 1'b0;
        check_ok_d   = 1'b0;
        check_err_d  = 1'b0;
        round_done_d = 1'b0;
`ifdef GEN_TIMEOUT_EN
        gen_timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                // Only the highest-priority request is acted on; an ignored one still masks lower ones.
                if (i_clear) begin
                    length_d  = '0;
                    chk_idx_d = '0;
                end else if (i_extend) begin
                    if (!o_full) state_d = REQ;
                end else if (i_play_start) begin
                    if (length_q != '0) begin
                        play_idx_d = '0;
                        timer_d    = '0;
                        state_d    = PLAY_ON;
                    end
                end else if (i_check_valid) begin
                    if (length_q == '0) begin
                        check_err_d = 1'b1;
                    end else if (i_check_value == mem[chk_idx_q[IDX_W-1:0]]) begin
                        check_ok_d = 1'b1;
                        if (chk_next == length_q) begin
                            round_done_d = 1'b1;
                            chk_idx_d    = '0;
                        end else begin
                            chk_idx_d = chk_next;
                        end
                    end else begin
                        check_err_d = 1'b1;
                        chk_idx_d   = '0;
                    end
                end
            end
            REQ: begin
                timer_d = '0;
                state_d = WAIT_GEN;
            end
            WAIT_GEN: begin
                if (i_gen_done) begin
                    mem_we    = 1'b1;
                    length_d  = length_q + LEN_W'(1);
                    chk_idx_d = '0;
                    state_d   = IDLE;
                end
`ifdef GEN_TIMEOUT_EN
                else if (timer_q == TMR_W'(GEN_TIMEOUT - 1)) begin
                    gen_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
`endif
            end
            PLAY_ON: begin
                if (timer_q == TMR_W'(ON_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = PLAY_OFF;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            PLAY_OFF: begin
                if (timer_q == TMR_W'(OFF_CYCLES - 1)) begin
                    timer_d    = '0;
                    play_idx_d = play_idx_q + LEN_W'(1);
                    state_d    = (play_idx_d < length_q) ? PLAY_ON : IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Colour register is loaded from the upcoming state so it aligns with PLAY_ON.
        play_color_d = (state_d == PLAY_ON) ? mem[play_idx_d[IDX_W-1:0]] : 3'd0;
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            length_q      <= '0;
            play_idx_q    <= '0;
            chk_idx_q     <= '0;
            timer_q       <= '0;
            o_gen_enable  <= 1'b0;
            o_gen_trigger <= 1'b0;
            o_play_color  <= 3'd0;
            o_busy        <= 1'b0;
            o_check_ok    <= 1'b0;
            o_check_err   <= 1'b0;
            o_round_done  <= 1'b0;
            o_full        <= 1'b0;
`ifdef GEN_TIMEOUT_EN
            o_gen_timeout <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            length_q      <= length_d;
            play_idx_q    <= play_idx_d;
            chk_idx_q     <= chk_idx_d;
            timer_q       <= timer_d;
            o_gen_enable  <= 1'b1;
            o_gen_trigger <= (state_d == REQ);
            o_play_color  <= play_color_d;
            o_busy        <= (state_d != IDLE);
            o_check_ok    <= check_ok_d;
            o_check_err   <= check_err_d;
            o_round_done  <= round_done_d;
            o_full        <= (length_d == LEN_W'(MAX_LEN));
`ifdef GEN_TIMEOUT_EN
            o_gen_timeout <= gen_timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_sequence_store_module.sv
// Self-checking bench for sequence_store_module (MAX_LEN=4, ON=4, OFF=2).
module tb_sequence_store_module;

    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned ON_C    = 4;
    localparam int unsigned OFF_C   = 2;
    localparam int unsigned GEN_TO  = 16;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_clear = 1'b0;
    logic             i_extend = 1'b0;
    logic             o_gen_enable;
    logic             o_gen_trigger;
    logic             i_gen_done = 1'b0;
    logic [2:0]       i_gen_value = 3'd0;
    logic             i_play_start = 1'b0;
    logic [2:0]       o_play_color;
    logic             o_busy;
    logic             i_check_valid = 1'b0;
    logic [2:0]       i_check_value = 3'd0;
    logic             o_check_ok;
    logic             o_check_err;
    logic             o_round_done;
`ifdef GEN_TIMEOUT_EN
    logic             o_gen_timeout;
`endif
    logic [LEN_W-1:0] o_length;
    logic             o_full;

    int n_pass = 0;
    int n_total = 0;

    // Reference model and scoreboards.
    int         exp_len = 0;
    int         exp_chk = 0;
    logic [2:0] exp_mem [MAX_LEN];
    logic [2:0] color_q [$];
    logic [2:0] press_q [$];   // {ok, err, round_done}

    sequence_store_module #(
        .MAX_LEN(MAX_LEN), .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .GEN_TIMEOUT(GEN_TO)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_extend(i_extend),
        .o_gen_enable(o_gen_enable), .o_gen_trigger(o_gen_trigger),
        .i_gen_done(i_gen_done), .i_gen_value(i_gen_value),
        .i_play_start(i_play_start), .o_play_color(o_play_color), .o_busy(o_busy),
        .i_check_valid(i_check_valid), .i_check_value(i_check_value),
        .o_check_ok(o_check_ok), .o_check_err(o_check_err), .o_round_done(o_round_done),
`ifdef GEN_TIMEOUT_EN
        .o_gen_timeout(o_gen_timeout),
`endif
        .o_length(o_length), .o_full(o_full)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [2:0] fold(input logic [2:0] v);
        return 3'(((int'(v) + 7) % 4) + 1);
    endfunction

    // Extend through a generator that answers one cycle after seeing the trigger.
    task automatic do_extend(input logic [2:0] v);
        int n;
        i_extend = 1'b1; tick; i_extend = 1'b0;
        n = 0;
        while (o_gen_trigger !== 1'b1 && n < 8) begin tick; n++; end
        n_total++;
        if (o_gen_trigger !== 1'b1) $display("FAIL extend_trigger: got %b want 1", o_gen_trigger);
        else n_pass++;
        tick;
        i_gen_done = 1'b1; i_gen_value = v; tick;
        i_gen_done = 1'b0; i_gen_value = 3'd0;
        if (exp_len < int'(MAX_LEN)) begin exp_mem[exp_len] = fold(v); exp_len++; end
        exp_chk = 0;
    endtask

    task automatic do_clear;
        i_clear = 1'b1; tick; i_clear = 1'b0;
        exp_len = 0; exp_chk = 0;
    endtask

    // Press a button: model result is queued, then compared with the DUT pulse.
    task automatic do_press(input logic [2:0] v);
        logic [2:0] exp;
        logic [2:0] got;
        if (exp_len == 0) exp = 3'b010;
        else if (v == exp_mem[exp_chk]) begin
            exp_chk++;
            if (exp_chk == exp_len) begin exp = 3'b101; exp_chk = 0; end
            else exp = 3'b100;
        end else begin
            exp = 3'b010; exp_chk = 0;
        end
        press_q.push_back(exp);
        i_check_valid = 1'b1; i_check_value = v; tick; i_check_valid = 1'b0;
        got = {o_check_ok, o_check_err, o_round_done};
        exp = press_q.pop_front();
        n_total++;
        if (got !== exp) $display("FAIL press_%0d: got ok/err/done=%b want %b", v, got, exp);
        else n_pass++;
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0; tick; tick;
        n_total++; if (o_gen_enable !== 1'b0) $display("FAIL rst_gen_enable: got %b want 0", o_gen_enable); else n_pass++;
        n_total++; if (o_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", o_busy); else n_pass++;
        n_total++; if (o_play_color !== 3'd0) $display("FAIL rst_color: got %0d want 0", o_play_color); else n_pass++;
        n_total++; if (o_length !== '0) $display("FAIL rst_length: got %0d want 0", o_length); else n_pass++;
        n_total++; if ({o_gen_trigger, o_check_ok, o_check_err, o_round_done, o_full} !== 5'b0)
            $display("FAIL rst_pulses: got %b want 00000", {o_gen_trigger, o_check_ok, o_check_err, o_round_done, o_full});
        else n_pass++;
        i_rst_n = 1'b1; tick;
        n_total++; if (o_gen_enable !== 1'b1) $display("FAIL gen_enable: got %b want 1", o_gen_enable); else n_pass++;
    endtask

    task automatic test_extend;
        i_extend = 1'b1; tick; i_extend = 1'b0;
        n_total++; if (o_gen_trigger !== 1'b1) $display("FAIL trigger_1cyc: got %b want 1", o_gen_trigger); else n_pass++;
        n_total++; if (o_busy !== 1'b1) $display("FAIL busy_req: got %b want 1", o_busy); else n_pass++;
        tick;
        n_total++; if (o_gen_trigger !== 1'b0) $display("FAIL trigger_single: got %b want 0", o_gen_trigger); else n_pass++;
        i_gen_done = 1'b1; i_gen_value = 3'd3; tick;
        i_gen_done = 1'b0; i_gen_value = 3'd0;
        exp_mem[0] = 3'd3; exp_len = 1; exp_chk = 0;
        n_total++; if (o_length !== LEN_W'(exp_len)) $display("FAIL len_after_extend: got %0d want %0d", o_length, exp_len); else n_pass++;
        do_press(3'd3);
    endtask

    task automatic test_playback;
        do_clear;
        n_total++; if (o_length !== '0) $display("FAIL clear_len: got %0d want 0", o_length); else n_pass++;
        do_extend(3'd2); do_extend(3'd4); do_extend(3'd1); do_extend(3'd3);
        n_total++; if (o_full !== 1'b1) $display("FAIL full: got %b want 1", o_full); else n_pass++;
        for (int i = 0; i < exp_len; i++) begin
            for (int k = 0; k < int'(ON_C); k++) color_q.push_back(exp_mem[i]);
            for (int k = 0; k < int'(OFF_C); k++) color_q.push_back(3'd0);
        end
        i_play_start = 1'b1; tick; i_play_start = 1'b0;
        while (color_q.size() > 0) begin
            logic [2:0] c;
            c = color_q.pop_front();
            n_total++;
            if (o_play_color !== c || o_busy !== 1'b1)
                $display("FAIL play_color: got %0d busy %b want %0d busy 1", o_play_color, o_busy, c);
            else n_pass++;
            tick;
        end
        n_total++; if (o_busy !== 1'b0 || o_play_color !== 3'd0)
            $display("FAIL play_end: got busy %b color %0d want 0 0", o_busy, o_play_color);
        else n_pass++;
    endtask

    task automatic test_full;
        logic seen;
        seen = 1'b0;
        i_extend = 1'b1; tick; i_extend = 1'b0;
        for (int k = 0; k < 4; k++) begin seen |= o_gen_trigger | o_busy; tick; end
        n_total++; if (seen !== 1'b0) $display("FAIL full_extend: got trigger/busy %b want 0", seen); else n_pass++;
        n_total++; if (o_length !== LEN_W'(MAX_LEN) || o_full !== 1'b1)
            $display("FAIL full_hold: got len %0d full %b want %0d 1", o_length, o_full, MAX_LEN);
        else n_pass++;
        do_clear;
        n_total++; if (o_length !== '0 || o_full !== 1'b0)
            $display("FAIL clear_full: got len %0d full %b want 0 0", o_length, o_full);
        else n_pass++;
        do_press(3'd1);
    endtask

    task automatic test_check;
        do_extend(3'd2); do_extend(3'd4); do_extend(3'd1);
        do_press(3'd2); do_press(3'd4); do_press(3'd1);
        do_press(3'd2); do_press(3'd3); do_press(3'd2);
    endtask

    task automatic test_fold;
        do_clear;
        do_extend(3'd0); do_extend(3'd5); do_extend(3'd7);
        do_press(3'd4); do_press(3'd1); do_press(3'd3);
    endtask

    task automatic test_priority;
        int n;
        do_clear;
        do_extend(3'd2);
        i_clear = 1'b1; i_extend = 1'b1; tick; i_clear = 1'b0; i_extend = 1'b0;
        exp_len = 0; exp_chk = 0;
        n_total++; if (o_gen_trigger !== 1'b0 || o_length !== '0)
            $display("FAIL prio_clear: got trig %b len %0d want 0 0", o_gen_trigger, o_length);
        else n_pass++;
        do_extend(3'd2);
        i_play_start = 1'b1; i_check_valid = 1'b1; i_check_value = 3'd2; tick;
        i_play_start = 1'b0; i_check_valid = 1'b0;
        n_total++; if (o_busy !== 1'b1 || o_check_ok !== 1'b0)
            $display("FAIL prio_play: got busy %b ok %b want 1 0", o_busy, o_check_ok);
        else n_pass++;
        n = 0;
        while (o_busy === 1'b1 && n < 40) begin tick; n++; end
        n_total++; if (n != int'(ON_C + OFF_C)) $display("FAIL play_len1: got %0d cycles want %0d", n, ON_C + OFF_C); else n_pass++;
    endtask

    task automatic test_reset_mid;
        do_extend(3'd4);
        i_play_start = 1'b1; tick; i_play_start = 1'b0;
        tick;
        i_rst_n = 1'b0; #1;
        n_total++; if (o_play_color !== 3'd0 || o_busy !== 1'b0)
            $display("FAIL rst_mid_play: got color %0d busy %b want 0 0", o_play_color, o_busy);
        else n_pass++;
        tick; i_rst_n = 1'b1; tick;
        exp_len = 0; exp_chk = 0;
        n_total++; if (o_length !== '0) $display("FAIL rst_mid_len: got %0d want 0", o_length); else n_pass++;
        i_extend = 1'b1; tick; i_extend = 1'b0; tick;
        i_rst_n = 1'b0; #1; i_rst_n = 1'b1;
        i_gen_done = 1'b1; i_gen_value = 3'd1; tick; i_gen_done = 1'b0; tick;
        n_total++; if (o_length !== '0 || o_busy !== 1'b0)
            $display("FAIL rst_mid_req: got len %0d busy %b want 0 0", o_length, o_busy);
        else n_pass++;
    endtask

`ifdef GEN_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        do_extend(3'd1);
        i_extend = 1'b1; tick; i_extend = 1'b0;
        n = 0;
        while (o_gen_timeout !== 1'b1 && n < 60) begin tick; n++; end
        n_total++; if (n != int'(GEN_TO) + 1) $display("FAIL timeout_lat: got %0d want %0d", n, GEN_TO + 1); else n_pass++;
        tick;
        n_total++; if (o_length !== LEN_W'(exp_len) || o_busy !== 1'b0)
            $display("FAIL timeout_len: got len %0d busy %b want %0d 0", o_length, o_busy, exp_len);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset;
        test_extend;
        test_playback;
        test_full;
        test_check;
        test_fold;
        test_priority;
        test_reset_mid;
`ifdef GEN_TIMEOUT_EN
        test_timeout;
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sequence_store_module.md
Name: sequence_store_module

Overview:
- Downstream consumer of the random-number generator in the Simon game.
- Requests one new colour (1-4) per round and appends it to an internal sequence memory.
- Plays the stored sequence back as timed colour codes for the LED/tone stage.
- Checks the player's button presses against the stored sequence, element by element.

Parameters:
- MAX_LEN, 32: maximum sequence length (elements).
- ON_CYCLES, 50: clocks each colour is shown during playback.
- OFF_CYCLES, 25: dark clocks after each colour during playback.
- GEN_TIMEOUT, 16: clocks to wait for the generator done pulse (used only with the optional feature).

Ports:
- i_clk  in  1  system clock, posedge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_clear  in  1  synchronous sequence clear; length <= 0.
- i_extend  in  1  one-cycle pulse; request and append one new element.
- o_gen_enable  out  1  generator enable; high whenever not in reset.
- o_gen_trigger  out  1  one-cycle generator trigger pulse.
- i_gen_done  in  1  generator done pulse.
- i_gen_value  in  3  generated colour 1-4, valid with i_gen_done.
- i_play_start  in  1  one-cycle pulse; start playback.
- o_play_color  out  3  0 = dark, 1-4 = colour currently shown.
- o_busy  out  1  high in any state except IDLE.
- i_check_valid  in  1  one-cycle player press strobe.
- i_check_value  in  3  pressed colour 1-4.
- o_check_ok  out  1  pulse: press matched the current element.
- o_check_err  out  1  pulse: press mismatched; check index resets.
- o_round_done  out  1  pulse: whole sequence entered correctly.
- o_length  out  $clog2(MAX_LEN+1)  stored element count.
- o_full  out  1  o_length == MAX_LEN.

Behaviour:
- Reset (async, i_rst_n low):
  - state IDLE; length, play index, check index and timers = 0.
  - o_gen_trigger, o_play_color, o_busy, o_check_ok, o_check_err, o_round_done = 0.
  - Memory contents are don't-care.
  - o_gen_enable = 0 in reset, 1 otherwise.
- FSM states: IDLE, REQ, WAIT_GEN, PLAY_ON, PLAY_OFF.
- IDLE priority, highest first: i_clear > i_extend > i_play_start > i_check_valid. Only the highest active request is acted on; lower ones in the same cycle are dropped.
- i_clear in IDLE: length and check index <= 0 next cycle.
- i_clear outside IDLE is ignored.
- i_extend with o_full = 1: ignored; stays IDLE.
- i_extend otherwise: go to REQ.
- REQ:
  - o_gen_trigger = 1 for exactly one cycle.
  - Next state WAIT_GEN.
- WAIT_GEN:
  - On i_gen_done, mem[length] <= i_gen_value; length += 1; check index <= 0; return to IDLE.
  - i_gen_value of 0 or >4 is stored as ((v-1) mod 4)+1 using the low 2 bits of v-1.
  - Latency from i_extend to length update is 3 cycles minimum.
- i_play_start with length 0: ignored.
- i_play_start otherwise: play index <= 0; go to PLAY_ON.
- PLAY_ON:
  - o_play_color = mem[play index] for ON_CYCLES clocks, then go to PLAY_OFF.
- PLAY_OFF:
  - o_play_color = 0 for OFF_CYCLES clocks.
  - Then play index += 1; go to PLAY_ON if play index < length, else IDLE.
  - Total playback time = length*(ON_CYCLES+OFF_CYCLES) clocks.
- o_play_color is registered and is 0 outside PLAY_ON.
- Check, in IDLE only (i_check_valid outside IDLE is ignored; no pulse):
  - With length 0: o_check_err pulses.
  - With i_check_value == mem[check index]: o_check_ok pulses and check index += 1.
    - If the new check index == length, o_round_done pulses in the same cycle as o_check_ok and check index <= 0.
  - Otherwise: o_check_err pulses and check index <= 0.
  - All check pulses are 1 cycle, registered, and appear 1 cycle after i_check_valid.
- Reset asserted mid-playback or mid-request: immediate return to reset values; a generator done pulse arriving after reset is ignored.

Optional Feature:
- Macro: GEN_TIMEOUT_EN.
- Defined:
  - WAIT_GEN counts clocks; if i_gen_done is absent after GEN_TIMEOUT clocks, return to IDLE with length unchanged.
  - Extra output o_gen_timeout (1 bit) pulses for one cycle on timeout.
- Undefined:
  - WAIT_GEN waits indefinitely.
  - No o_gen_timeout port.

Test Plan:
- Reset, then i_extend with generator model returning 3 -> o_gen_trigger single pulse 1 cycle after i_extend; o_length = 1; mem[0] = 3.
- Extend 4 times (values 2,4,1,3), pulse i_play_start (ON=4, OFF=2) -> o_play_color sequence 2x4, 0x2, 4x4, 0x2, 1x4, 0x2, 3x4, 0x2; o_busy low after 24 cycles.
- With stored sequence 2,4,1: presses 2,4,1 -> o_check_ok x3; o_round_done with the third. Presses 2,3 -> ok, then err; next press 2 -> ok (index restarted).
- Fill to MAX_LEN=4, then i_extend -> no o_gen_trigger; o_length stays 4; o_full = 1. i_clear -> o_length 0, o_full 0.
- i_rst_n low during PLAY_ON -> o_play_color 0 and o_busy 0 immediately; o_length 0 after release.
- GEN_TIMEOUT_EN defined, generator silent -> o_gen_timeout pulse GEN_TIMEOUT cycles after entering WAIT_GEN; o_length unchanged.
